// File: rtl/dtc_pkg.sv
// Shared types for the DTC slow-control path: arbiter states, grant
// owners, the read-flag bit position and the receiver's command codes.
package dtc_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_DTC = 1'b0,
        GNT_LOC = 1'b1
    } gnt_e;

    localparam int DTC_RD_BIT = 31;

    localparam logic [3:0] DTC_CMD_NOP = 4'h0;
    localparam logic [3:0] DTC_CMD_WR  = 4'h1;
    localparam logic [3:0] DTC_CMD_RD  = 4'h2;

endpackage

// File: rtl/dtc_reg_arbiter_if.sv
// FEC internal register bus.
// master: reg_addr/reg_wdata/reg_wr/reg_rd out, reg_rdata/reg_ack in.
interface dtc_reg_arbiter_if #(
    parameter int ADDR_W = 16
) ();

    logic [ADDR_W-1:0] reg_addr;
    logic [31:0]       reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [31:0]       reg_rdata;
    logic              reg_ack;

    modport master (
        output reg_addr, reg_wdata, reg_wr, reg_rd,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_wr, reg_rd,
        output reg_rdata, reg_ack
    );

endinterface

// File: rtl/dtc_cmd_slot.sv
// One-deep holding register for DTC command pulses with sticky overflow.
// Ports: load/load_* capture a pulse, grant empties, ovf_clr clears ovf.
module dtc_cmd_slot #(
    parameter int ADDR_W = 16
) (
    input  logic              dtc_clk_90,
    input  logic              rst_n,
    input  logic              load,
    input  logic              load_rd,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              grant,
    input  logic              ovf_clr,
    output logic              pend,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       data,
    output logic              ovf
);

    always_ff @(posedge dtc_clk_90) begin
        if (!rst_n) begin
            pend <= 1'b0;
            rd   <= 1'b0;
            addr <= '0;
            data <= '0;
            ovf  <= 1'b0;
        end else begin
            // a grant frees the slot in the same edge, so a new
            // pulse can take its place without being lost
            if (load && (!pend || grant)) begin
                pend <= 1'b1;
                rd   <= load_rd;
                addr <= load_addr;
                data <= load_data;
            end else if (grant) begin
                pend <= 1'b0;
            end

            if (ovf_clr) begin
                ovf <= 1'b0;
            end else if (load && pend && !grant) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dtc_reg_arbiter.sv
// Shares the register bus between DTC commands and a local requester.
// Ports: DTC pulses, local valid/ready, bus (master), responses, dtc_ovf.
module dtc_reg_arbiter
    import dtc_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              dtc_clk_90,
    input  logic              rst_n,
    input  logic              dtc_write,
    input  logic              dtc_read,
    input  logic [31:0]       dtc_addr,
    input  logic [31:0]       dtc_data,
    input  logic              loc_valid,
    output logic              loc_ready,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [31:0]       loc_wdata,
    dtc_reg_arbiter_if.master bus,
    output logic              dtc_rsp_valid,
    output logic              loc_rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              dtc_ovf,
    input  logic              dtc_ovf_clr
);

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 1);

    arb_state_e        state_q, state_d;
    gnt_e              last_q, last_d;
    gnt_e              own_q, own_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              rds_q, rds_d;
    logic [9:0]        cnt_q, cnt_d;
    logic              dvld_q, dvld_d;
    logic              lvld_q, lvld_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              s_pend, s_rd;
    logic [ADDR_W-1:0] s_addr;
    logic [31:0]       s_data;
    logic              idle, gnt_loc, gnt_dtc, tmo;
    logic [31:0]       unused_dtc_addr;

    assign unused_dtc_addr = dtc_addr;

    dtc_cmd_slot #(.ADDR_W(ADDR_W)) u_slot (
        .dtc_clk_90 (dtc_clk_90),
        .rst_n      (rst_n),
        .load       (dtc_write | dtc_read),
        .load_rd    (dtc_addr[DTC_RD_BIT]),
        .load_addr  (dtc_addr[ADDR_W-1:0]),
        .load_data  (dtc_data),
        .grant      (gnt_dtc),
        .ovf_clr    (dtc_ovf_clr),
        .pend       (s_pend),
        .rd         (s_rd),
        .addr       (s_addr),
        .data       (s_data),
        .ovf        (dtc_ovf)
    );

    // local wins when alone or when DTC took the previous grant
    assign idle    = (state_q == ARB_IDLE);
    assign gnt_loc = idle && loc_valid && (!s_pend || last_q == GNT_DTC);
    assign gnt_dtc = idle && s_pend && !gnt_loc;
    assign tmo     = (state_q == ARB_BUS) && (cnt_q == TO_LAST);

    assign loc_ready     = gnt_loc;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_rd    = rds_q;
    assign dtc_rsp_valid = dvld_q;
    assign loc_rsp_valid = lvld_q;
    assign rsp_data      = rdata_q;
    assign rsp_err       = err_q;

    always_ff @(posedge dtc_clk_90) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (gnt_loc || gnt_dtc) state_d = ARB_BUS;
            ARB_BUS:  if (bus.reg_ack || tmo) state_d = ARB_RSP;
            ARB_RSP:  state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        last_d  = last_q;
        own_d   = own_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rds_d   = rds_q;
        cnt_d   = cnt_q;
        dvld_d  = 1'b0;
        lvld_d  = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                unique case (1'b1)
                    gnt_loc: begin
                        last_d  = GNT_LOC;
                        own_d   = GNT_LOC;
                        addr_d  = loc_addr;
                        wdata_d = loc_wdata;
                        wr_d    = loc_we;
                        rds_d   = !loc_we;
                    end
                    gnt_dtc: begin
                        last_d  = GNT_DTC;
                        own_d   = GNT_DTC;
                        addr_d  = s_addr;
                        wdata_d = s_data;
                        wr_d    = !s_rd;
                        rds_d   = s_rd;
                    end
                    default: ;
                endcase
            end
            ARB_BUS: begin
                cnt_d = cnt_q + 10'd1;
                // an ack on the limit cycle still completes normally
                if (bus.reg_ack || tmo) begin
                    wr_d    = 1'b0;
                    rds_d   = 1'b0;
                    err_d   = !bus.reg_ack;
                    rdata_d = (bus.reg_ack && rds_q) ? bus.reg_rdata : '0;
                    dvld_d  = (own_q == GNT_DTC);
                    lvld_d  = (own_q == GNT_LOC);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge dtc_clk_90) begin
        if (!rst_n) begin
            last_q  <= GNT_LOC;
            own_q   <= GNT_DTC;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rds_q   <= 1'b0;
            cnt_q   <= '0;
            dvld_q  <= 1'b0;
            lvld_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            last_q  <= last_d;
            own_q   <= own_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rds_q   <= rds_d;
            cnt_q   <= cnt_d;
            dvld_q  <= dvld_d;
            lvld_q  <= lvld_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
